// File: rtl/hazard_unit_if.sv
// rtl/hazard_unit_if.sv - hazard inputs and per-stage {Stall, Flush} control bundles
// Control bundles are packed as [1] = Stall, [0] = Flush.
interface hazard_unit_if;
    logic [4:0] ID_RsAddr;
    logic [4:0] ID_RtAddr;
    logic       ID_UsesRs;
    logic       ID_UsesRt;
    logic       ID_UsesHiLo;
    logic       EX_MemRead;
    logic [4:0] EX_RtAddr;
    logic       EX_MdStart;
    logic       EX_Redirect;
    logic       IMem_Ready;
    logic       DMem_Ready;

    logic       PC_Stall;
    logic [1:0] IF_ID_Cntl;
    logic [1:0] ID_EX_Cntl;
    logic [1:0] EX_MEM_Cntl;
    logic [1:0] MEM_WB_Cntl;
    logic       Redir_Replay;
    logic       MD_Busy;

    modport master (
        output ID_RsAddr, ID_RtAddr, ID_UsesRs, ID_UsesRt, ID_UsesHiLo,
               EX_MemRead, EX_RtAddr, EX_MdStart, EX_Redirect,
               IMem_Ready, DMem_Ready,
        input  PC_Stall, IF_ID_Cntl, ID_EX_Cntl, EX_MEM_Cntl, MEM_WB_Cntl,
               Redir_Replay, MD_Busy
    );

    modport slave (
        input  ID_RsAddr, ID_RtAddr, ID_UsesRs, ID_UsesRt, ID_UsesHiLo,
               EX_MemRead, EX_RtAddr, EX_MdStart, EX_Redirect,
               IMem_Ready, DMem_Ready,
        output PC_Stall, IF_ID_Cntl, ID_EX_Cntl, EX_MEM_Cntl, MEM_WB_Cntl,
               Redir_Replay, MD_Busy
    );
endinterface

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline stall/flush arbitration for the 5-stage MIPS core
// Priority: DMem freeze > KILL recovery > EX redirect > load-use/HI-LO > fetch miss.
module hazard_unit #(
    parameter int MD_LAT = 8
) (
    input  logic          Clk,
    input  logic          Rst_n,
    hazard_unit_if.slave  hif
);
    localparam int             CW      = $clog2(MD_LAT + 1);
    localparam logic [CW-1:0]  MD_LOAD = CW'(MD_LAT);
    localparam logic [1:0]     C_STALL = 2'b10;
    localparam logic [1:0]     C_FLUSH = 2'b01;

    typedef enum logic {RUN, KILL} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_md_cnt;

    logic            w_freeze;
    logic            w_lu_hz;
    logic            w_md_hz;
    logic            w_md_busy;
    logic            w_pc_stall;
    logic            w_replay;
    logic [1:0]      w_if_id;
    logic [1:0]      w_id_ex;
    logic [1:0]      w_ex_mem;
    logic [1:0]      w_mem_wb;

    assign w_freeze  = !hif.DMem_Ready;
    assign w_md_busy = (r_md_cnt != '0);
    assign w_lu_hz   = hif.EX_MemRead && (hif.EX_RtAddr != 5'd0) &&
                       ((hif.ID_UsesRs && (hif.ID_RsAddr == hif.EX_RtAddr)) ||
                        (hif.ID_UsesRt && (hif.ID_RtAddr == hif.EX_RtAddr)));
    assign w_md_hz   = hif.ID_UsesHiLo && w_md_busy;

    always_comb begin
        w_pc_stall = 1'b0;
        w_replay   = 1'b0;
        w_if_id    = 2'b00;
        w_id_ex    = 2'b00;
        w_ex_mem   = 2'b00;
        w_mem_wb   = 2'b00;
        if (!Rst_n) begin
            w_pc_stall = 1'b0;
        end else if (w_freeze) begin
            w_pc_stall = 1'b1;
            w_if_id    = C_STALL;
            w_id_ex    = C_STALL;
            w_ex_mem   = C_STALL;
            w_mem_wb   = C_FLUSH;
        end else if (r_state == KILL) begin
            // The stale fetch word is discarded even on the cycle it finally arrives.
            w_pc_stall = 1'b1;
            w_if_id    = C_FLUSH;
            w_id_ex    = hif.EX_Redirect ? C_FLUSH : 2'b00;
            w_replay   = hif.IMem_Ready;
        end else if (hif.EX_Redirect) begin
            w_pc_stall = !hif.IMem_Ready;
            w_if_id    = C_FLUSH;
            w_id_ex    = C_FLUSH;
        end else if (w_lu_hz || w_md_hz) begin
            w_pc_stall = 1'b1;
            w_if_id    = C_STALL;
            w_id_ex    = C_FLUSH;
        end else if (!hif.IMem_Ready) begin
            w_pc_stall = 1'b1;
            w_if_id    = C_FLUSH;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state  <= RUN;
            r_md_cnt <= '0;
        end else begin
            if (!w_freeze) begin
                case (r_state)
                    RUN:     if (hif.EX_Redirect && !hif.IMem_Ready) r_state <= KILL;
                    KILL:    if (hif.IMem_Ready) r_state <= RUN;
                    default: r_state <= RUN;
                endcase
            end
            // Counter keeps draining through frozen cycles; only the reload is blocked.
            if (hif.EX_MdStart && !w_freeze)
                r_md_cnt <= MD_LOAD;
            else if (w_md_busy)
                r_md_cnt <= r_md_cnt - 1'b1;
        end
    end

    assign hif.PC_Stall     = w_pc_stall;
    assign hif.IF_ID_Cntl   = w_if_id;
    assign hif.ID_EX_Cntl   = w_id_ex;
    assign hif.EX_MEM_Cntl  = w_ex_mem;
    assign hif.MEM_WB_Cntl  = w_mem_wb;
    assign hif.Redir_Replay = w_replay;
    assign hif.MD_Busy      = Rst_n && w_md_busy;
endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - scoreboard bench for hazard_unit with directed vectors
module tb_hazard_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_unit_if hif ();

    hazard_unit #(.MD_LAT(8)) dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .hif   (hif.slave)
    );

    typedef struct {
        string      nm;
        logic [10:0] e;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [1:0] S = 2'b10;
    localparam logic [1:0] F = 2'b01;
    localparam logic [1:0] N = 2'b00;

    function automatic logic [10:0] E(input logic pc, input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] c, input logic [1:0] d,
                                      input logic rr, input logic bsy);
        return {pc, a, b, c, d, rr, bsy};
    endfunction

    task automatic idle();
        hif.ID_RsAddr   = 5'd0;
        hif.ID_RtAddr   = 5'd0;
        hif.ID_UsesRs   = 1'b0;
        hif.ID_UsesRt   = 1'b0;
        hif.ID_UsesHiLo = 1'b0;
        hif.EX_MemRead  = 1'b0;
        hif.EX_RtAddr   = 5'd0;
        hif.EX_MdStart  = 1'b0;
        hif.EX_Redirect = 1'b0;
        hif.IMem_Ready  = 1'b1;
        hif.DMem_Ready  = 1'b1;
    endtask

    task automatic step(input string nm, input logic [10:0] e);
        sb.push_back('{nm, e});
        @(posedge clk);
        #1;
    endtask

    task automatic set_lu(input logic [4:0] exrt, input logic [4:0] rs);
        hif.EX_MemRead = 1'b1;
        hif.EX_RtAddr  = exrt;
        hif.ID_RsAddr  = rs;
        hif.ID_UsesRs  = 1'b1;
    endtask

    // Monitor: compares the oldest expectation against the DUT once per cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t it;
            logic [10:0] act;
            it  = sb.pop_front();
            act = {hif.PC_Stall, hif.IF_ID_Cntl, hif.ID_EX_Cntl, hif.EX_MEM_Cntl,
                   hif.MEM_WB_Cntl, hif.Redir_Replay, hif.MD_Busy};
            checks++;
            if (act !== it.e) begin
                errors++;
                $display("FAIL %s: got %b expected %b", it.nm, act, it.e);
            end
        end
    end

    initial begin
        idle();
        @(posedge clk);
        #1;
        step("reset", E(0, N, N, N, N, 0, 0));
        rst_n = 1'b1;
        step("idle", E(0, N, N, N, N, 0, 0));

        // Load-use
        set_lu(5'd5, 5'd5);
        step("lu_rs", E(1, S, F, N, N, 0, 0));
        idle();
        step("lu_after", E(0, N, N, N, N, 0, 0));
        set_lu(5'd0, 5'd0);
        step("lu_r0", E(0, N, N, N, N, 0, 0));
        idle();
        hif.EX_MemRead = 1'b1; hif.EX_RtAddr = 5'd7; hif.ID_RtAddr = 5'd7; hif.ID_UsesRt = 1'b1;
        step("lu_rt", E(1, S, F, N, N, 0, 0));
        hif.ID_UsesRt = 1'b0;
        step("lu_nouse", E(0, N, N, N, N, 0, 0));

        // Mul/div single issue
        idle();
        hif.EX_MdStart = 1'b1; hif.ID_UsesHiLo = 1'b1;
        step("md_start", E(0, N, N, N, N, 0, 0));
        hif.EX_MdStart = 1'b0;
        for (int i = 1; i <= 8; i++) step($sformatf("md_busy%0d", i), E(1, S, F, N, N, 0, 1));
        step("md_release", E(0, N, N, N, N, 0, 0));

        // Mul/div reissue at t+3 extends release to t+12
        hif.EX_MdStart = 1'b1;
        step("md2_start", E(0, N, N, N, N, 0, 0));
        hif.EX_MdStart = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            hif.EX_MdStart = (i == 3);
            step($sformatf("md2_busy%0d", i), E(1, S, F, N, N, 0, 1));
        end
        hif.EX_MdStart = 1'b0;
        step("md2_release", E(0, N, N, N, N, 0, 0));

        // Redirect during fetch miss
        idle();
        hif.IMem_Ready = 1'b0; hif.EX_Redirect = 1'b1;
        step("redir_miss", E(1, F, F, N, N, 0, 0));
        hif.EX_Redirect = 1'b0;
        step("kill1", E(1, F, N, N, N, 0, 0));
        hif.EX_Redirect = 1'b1;
        step("kill2_redir", E(1, F, F, N, N, 0, 0));
        hif.EX_Redirect = 1'b0;
        step("kill3", E(1, F, N, N, N, 0, 0));
        hif.IMem_Ready = 1'b1;
        step("kill_replay", E(1, F, N, N, N, 1, 0));
        step("kill_done", E(0, N, N, N, N, 0, 0));

        // Redirect with fetch ready stays in RUN
        hif.EX_Redirect = 1'b1;
        step("redir_hit", E(0, F, F, N, N, 0, 0));
        hif.EX_Redirect = 1'b0;
        step("redir_hit_run", E(0, N, N, N, N, 0, 0));

        // Freeze priority over redirect, load-use and miss
        hif.DMem_Ready = 1'b0; hif.EX_Redirect = 1'b1; hif.IMem_Ready = 1'b0;
        set_lu(5'd9, 5'd9);
        step("freeze_all", E(1, S, S, S, F, 0, 0));
        hif.DMem_Ready = 1'b1; hif.IMem_Ready = 1'b1;
        step("freeze_exit_redir", E(0, F, F, N, N, 0, 0));
        idle();
        step("freeze_run", E(0, N, N, N, N, 0, 0));

        // Freeze while in KILL holds state and suppresses replay
        hif.EX_Redirect = 1'b1; hif.IMem_Ready = 1'b0;
        step("k_enter", E(1, F, F, N, N, 0, 0));
        hif.EX_Redirect = 1'b0; hif.IMem_Ready = 1'b1; hif.DMem_Ready = 1'b0;
        step("k_freeze", E(1, S, S, S, F, 0, 0));
        hif.DMem_Ready = 1'b1;
        step("k_replay", E(1, F, N, N, N, 1, 0));
        step("k_run", E(0, N, N, N, N, 0, 0));

        // MdStart during freeze is not loaded
        hif.DMem_Ready = 1'b0; hif.EX_MdStart = 1'b1;
        step("md_frozen", E(1, S, S, S, F, 0, 0));
        idle();
        step("md_frozen_noload", E(0, N, N, N, N, 0, 0));

        // Plain fetch miss
        hif.IMem_Ready = 1'b0;
        step("miss1", E(1, F, N, N, N, 0, 0));
        step("miss2", E(1, F, N, N, N, 0, 0));
        idle();
        step("miss_done", E(0, N, N, N, N, 0, 0));

        // Async reset while in KILL with md_cnt=5
        hif.EX_MdStart = 1'b1;
        step("ar_start", E(0, N, N, N, N, 0, 0));
        hif.EX_MdStart = 1'b0;
        step("ar_busy8", E(0, N, N, N, N, 0, 1));
        hif.EX_Redirect = 1'b1; hif.IMem_Ready = 1'b0;
        step("ar_kill_enter", E(1, F, F, N, N, 0, 1));
        hif.EX_Redirect = 1'b0;
        step("ar_kill", E(1, F, N, N, N, 0, 1));
        rst_n = 1'b0;
        step("ar_reset", E(0, N, N, N, N, 0, 0));
        step("ar_reset_hold", E(0, N, N, N, N, 0, 0));
        rst_n = 1'b1;
        hif.IMem_Ready = 1'b1;
        step("ar_after", E(0, N, N, N, N, 0, 0));

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
